// File: rtl/adc_scan_pkg.sv
// ============================================================================
// adc_scan_pkg : shared types, constants and slot-search helper for the
//                multi-channel ADC scan engine.
// Rev 1.0
// ============================================================================
`default_nettype none

package adc_scan_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    SCALE = 3'd3,
    STORE = 3'd4,
    NEXT  = 3'd5
  } scan_state_e;

  localparam int ADC_FULL   = 4095;
  localparam int BCD_DIGITS = 4;

  // First masked slot at or after ptr, wrapping modulo 8; unused upper mask bits are 0.
  function automatic logic [2:0] next_slot(input logic [7:0] mask, input logic [2:0] ptr);
    logic [2:0] idx;
    next_slot = ptr;
    for (int k = 7; k >= 0; k--) begin
      idx = ptr + 3'(k);
      if (mask[idx]) next_slot = idx;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/adc_bcd_conv.sv
// ============================================================================
// adc_bcd_conv : sequential double-dabble, MV_W-bit binary to 4-digit BCD,
//                one bit per cycle, saturating at 9999.
// Rev 1.0
// ============================================================================
`default_nettype none

module adc_bcd_conv
  import adc_scan_pkg::*;
#(
  parameter int MV_W = 13
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [MV_W-1:0]         bin_i,
  output logic [4*BCD_DIGITS-1:0] bcd_o,
  output logic                    done_o
);

  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int CNT_W = $clog2(MV_W + 1);

  logic             busy_q;
  logic             sat_q;
  logic [MV_W-1:0]  sh_q;
  logic [BCD_W-1:0] work_q;
  logic [CNT_W-1:0] cnt_q;
  logic [BCD_W-1:0] w_adj;
  logic [BCD_W-1:0] w_shift;

  always_comb begin
    w_adj = work_q;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (work_q[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = work_q[4*d +: 4] + 4'd3;
    end
  end

  assign w_shift = {w_adj[BCD_W-2:0], sh_q[MV_W-1]};
  assign done_o  = busy_q && (cnt_q == CNT_W'(MV_W - 1));
  assign bcd_o   = sat_q ? {BCD_DIGITS{4'h9}} : w_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      sat_q  <= 1'b0;
      sh_q   <= '0;
      work_q <= '0;
      cnt_q  <= '0;
    end else if (busy_q) begin
      work_q <= w_shift;
      sh_q   <= sh_q << 1;
      cnt_q  <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      sat_q  <= (32'(bin_i) > 32'd9999);
      sh_q   <= bin_i;
      work_q <= '0;
      cnt_q  <= '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/adc_channel_scanner.sv
// ============================================================================
// adc_channel_scanner : round-robin MAX10 ADC scan engine with per-slot mV
//                       scaling and BCD display of one selected slot.
// Optional block averaging enabled by defining ADC_SCAN_AVG_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module adc_channel_scanner
  import adc_scan_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int FIRST_CH    = 1,
  parameter int VREF_MV     = 5000,
  parameter int MV_W        = 13,
  parameter int TIMEOUT_CYC = 1024,
  parameter int AVG_LOG2    = 2
) (
  input  logic                   Clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [NUM_CH-1:0]      ch_mask,
  output logic                   cmd_valid,
  output logic [4:0]             cmd_channel,
  output logic                   cmd_sop,
  output logic                   cmd_eop,
  input  logic                   cmd_ready,
  input  logic                   rsp_valid,
  input  logic [4:0]             rsp_channel,
  input  logic [11:0]            rsp_data,
  input  logic [2:0]             disp_sel,
  output logic [NUM_CH*MV_W-1:0] mv_out,
  output logic [15:0]            bcd_out,
  output logic                   upd_strobe,
  output logic [2:0]             upd_slot,
  output logic                   timeout_err
);

  localparam int PROD_W = 12 + MV_W;
  localparam int CNT_W  = $clog2(MV_W + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

  if (NUM_CH < 1 || NUM_CH > 8 || AVG_LOG2 < 1) begin : g_param_check
    $error("adc_channel_scanner: NUM_CH must be 1..8 and AVG_LOG2 >= 1");
  end

  scan_state_e       state_q, state_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [PROD_W-1:0] rem_q, rem_d, div_q, div_d;
  logic [MV_W-1:0]   quot_q, quot_d;
  logic [CNT_W-1:0]  bit_q, bit_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              to_err_q, to_err_d;
  logic              upd_q;
  logic [2:0]        upd_slot_q;
  logic [MV_W-1:0]   mv_q [NUM_CH];
  logic [15:0]       bcd_q;
  logic [7:0]        w_mask8;
  logic [4:0]        w_cur_ch;
  logic [MV_W-1:0]   w_disp_mv;
  logic [15:0]       w_bcd;
  logic              w_bcd_done;

  always_comb begin
    w_mask8 = '0;
    w_mask8[NUM_CH-1:0] = ch_mask;
  end

  assign w_cur_ch    = 5'(FIRST_CH) + 5'(ptr_q);
  assign cmd_channel = (state_q == ISSUE) ? w_cur_ch : 5'd0;
  assign cmd_sop     = 1'b1;
  assign cmd_eop     = 1'b1;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    div_d     = div_q;
    quot_d    = quot_q;
    bit_d     = bit_q;
    to_d      = to_q;
    to_err_d  = 1'b0;
    cmd_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && (|ch_mask)) begin
          ptr_d   = next_slot(w_mask8, ptr_q);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cmd_valid = 1'b1;
        to_d      = '0;
        if (cmd_ready) state_d = WAIT;
      end
      WAIT: begin
        if (rsp_valid && (rsp_channel == w_cur_ch)) begin
          rem_d   = PROD_W'(rsp_data) * PROD_W'(VREF_MV);
          div_d   = PROD_W'(ADC_FULL) << (MV_W - 1);
          quot_d  = '0;
          bit_d   = '0;
          state_d = SCALE;
        end else if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
          to_err_d = 1'b1;
          state_d  = NEXT;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      // Restoring division: the quotient fits MV_W bits because VREF_MV < 2**MV_W.
      SCALE: begin
        if (rem_q >= div_q) begin
          rem_d  = rem_q - div_q;
          quot_d = {quot_q[MV_W-2:0], 1'b1};
        end else begin
          quot_d = {quot_q[MV_W-2:0], 1'b0};
        end
        div_d = div_q >> 1;
        bit_d = bit_q + 1'b1;
        if (bit_q == CNT_W'(MV_W - 1)) state_d = STORE;
      end
      STORE: state_d = NEXT;
      NEXT: begin
        ptr_d   = next_slot(w_mask8, ptr_q + 3'd1);
        state_d = (enable && (|ch_mask)) ? ISSUE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      quot_q   <= '0;
      bit_q    <= '0;
      to_q     <= '0;
      to_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      quot_q   <= quot_d;
      bit_q    <= bit_d;
      to_q     <= to_d;
      to_err_q <= to_err_d;
    end
  end

`ifdef ADC_SCAN_AVG_EN
  localparam int ACC_W = MV_W + AVG_LOG2;
  logic [ACC_W-1:0]    acc_q     [NUM_CH];
  logic [AVG_LOG2-1:0] avg_cnt_q [NUM_CH];
`endif

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        mv_q[i] <= '0;
`ifdef ADC_SCAN_AVG_EN
        acc_q[i]     <= '0;
        avg_cnt_q[i] <= '0;
`endif
      end
      upd_q      <= 1'b0;
      upd_slot_q <= '0;
    end else begin
      upd_q <= 1'b0;
      if (state_q == STORE) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ptr_q == 3'(i)) begin
`ifdef ADC_SCAN_AVG_EN
            if (avg_cnt_q[i] == '1) begin
              mv_q[i]      <= MV_W'((acc_q[i] + ACC_W'(quot_q)) >> AVG_LOG2);
              acc_q[i]     <= '0;
              avg_cnt_q[i] <= '0;
              upd_q        <= 1'b1;
              upd_slot_q   <= ptr_q;
            end else begin
              acc_q[i]     <= acc_q[i] + ACC_W'(quot_q);
              avg_cnt_q[i] <= avg_cnt_q[i] + 1'b1;
            end
`else
            mv_q[i]    <= quot_q;
            upd_q      <= 1'b1;
            upd_slot_q <= ptr_q;
`endif
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_mv_out
    assign mv_out[g*MV_W +: MV_W] = mv_q[g];
  end

  always_comb begin
    w_disp_mv = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (disp_sel == 3'(i)) w_disp_mv = mv_q[i];
    end
  end

  adc_bcd_conv #(
    .MV_W (MV_W)
  ) u_bcd (
    .clk     (Clk),
    .rst_n   (reset_n),
    .start_i (1'b1),
    .bin_i   (w_disp_mv),
    .bcd_o   (w_bcd),
    .done_o  (w_bcd_done)
  );

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n)        bcd_q <= '0;
    else if (w_bcd_done) bcd_q <= w_bcd;
  end

  assign bcd_out     = bcd_q;
  assign upd_strobe  = upd_q;
  assign upd_slot    = upd_slot_q;
  assign timeout_err = to_err_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_channel_scanner.sv
// ============================================================================
// tb_adc_channel_scanner : directed scoreboard bench for adc_channel_scanner.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_adc_channel_scanner;

  localparam int NUM_CH      = 4;
  localparam int MV_W        = 13;
  localparam int TIMEOUT_CYC = 1024;

  logic                   Clk = 1'b0;
  logic                   reset_n, enable, cmd_ready, rsp_valid;
  logic [NUM_CH-1:0]      ch_mask;
  logic [4:0]             rsp_channel;
  logic [11:0]            rsp_data;
  logic [2:0]             disp_sel;
  logic                   cmd_valid, cmd_sop, cmd_eop, upd_strobe, timeout_err;
  logic [4:0]             cmd_channel;
  logic [NUM_CH*MV_W-1:0] mv_out;
  logic [15:0]            bcd_out;
  logic [2:0]             upd_slot;

  always #5 Clk = ~Clk;

  adc_channel_scanner dut (
    .Clk(Clk), .reset_n(reset_n), .enable(enable), .ch_mask(ch_mask),
    .cmd_valid(cmd_valid), .cmd_channel(cmd_channel), .cmd_sop(cmd_sop), .cmd_eop(cmd_eop),
    .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_channel(rsp_channel), .rsp_data(rsp_data),
    .disp_sel(disp_sel), .mv_out(mv_out), .bcd_out(bcd_out), .upd_strobe(upd_strobe),
    .upd_slot(upd_slot), .timeout_err(timeout_err)
  );

  typedef struct {int slot; int mv;} exp_t;
  exp_t sb[$];

  int n_cmp = 0, n_fail = 0;
  int exp_mv[NUM_CH];
  int acc_m[NUM_CH];
  int cnt_m[NUM_CH];
  int strobes = 0, pushes = 0;
  int to_cnt, st_cnt, n_cmd, strobes0, pushes0;
  int t6[4] = '{0, 0, 4095, 4095};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int mv_of(input int d);
    return (d * 5000) / 4095;
  endfunction

  function automatic logic [15:0] bcd_of(input int v);
    logic [15:0] r;
    int x;
    x = (v > 9999) ? 9999 : v;
    r[15:12] = 4'(x / 1000);
    r[11:8]  = 4'((x / 100) % 10);
    r[7:4]   = 4'((x / 10) % 10);
    r[3:0]   = 4'(x % 10);
    return r;
  endfunction

  task automatic model_sample(input int slot, input int d);
    exp_t e;
    int   q;
    q = mv_of(d);
`ifdef ADC_SCAN_AVG_EN
    acc_m[slot] += q;
    cnt_m[slot]++;
    if (cnt_m[slot] == 4) begin
      e.slot = slot; e.mv = acc_m[slot] >> 2;
      sb.push_back(e); pushes++;
      acc_m[slot] = 0; cnt_m[slot] = 0;
    end
`else
    e.slot = slot; e.mv = q;
    sb.push_back(e); pushes++;
`endif
  endtask

  task automatic wait_cmd(input int exp_ch);
    int n = 0;
    while (cmd_valid !== 1'b1 && n < 2000) begin @(negedge Clk); n++; end
    chk("cmd_valid_seen", 64'(cmd_valid), 64'd1);
    chk("cmd_channel", 64'(cmd_channel), 64'(exp_ch));
    cmd_ready = 1'b1;
    @(negedge Clk);
    cmd_ready = 1'b0;
  endtask

  task automatic respond(input int ch, input int d);
    rsp_valid = 1'b1; rsp_channel = 5'(ch); rsp_data = 12'(d);
    @(negedge Clk);
    rsp_valid = 1'b0;
  endtask

  task automatic sample(input int slot, input int d);
    wait_cmd(slot + 1);
    respond(slot + 1, d);
    model_sample(slot, d);
  endtask

  task automatic collect();
    for (int i = 1; i <= 40; i++) begin
      @(negedge Clk);
      if (upd_strobe === 1'b1) begin
        strobes++;
        chk("strobe_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("upd_slot", 64'(upd_slot), 64'(e.slot));
          chk("mv_out_slot", 64'(mv_out[e.slot*MV_W +: MV_W]), 64'(e.mv));
          chk("strobe_latency", 64'(i), 64'(MV_W + 1));
          exp_mv[e.slot] = e.mv;
        end
      end
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_bcd(input int sel);
    logic [15:0] want;
    disp_sel = 3'(sel);
    repeat (2 * MV_W + 3) @(negedge Clk);
    want = (sel < NUM_CH) ? bcd_of(exp_mv[sel]) : 16'h0000;
    chk("bcd_out", 64'(bcd_out), 64'(want));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NUM_CH; i++) begin exp_mv[i] = 0; acc_m[i] = 0; cnt_m[i] = 0; end
    reset_n = 1'b0; enable = 1'b0; ch_mask = '0; cmd_ready = 1'b0;
    rsp_valid = 1'b0; rsp_channel = '0; rsp_data = '0; disp_sel = '0;
    repeat (3) @(negedge Clk);
    chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("rst_cmd_channel", 64'(cmd_channel), 64'd0);
    chk("rst_sop_eop", 64'({cmd_sop, cmd_eop}), 64'd3);
    chk("rst_mv_out", 64'(mv_out), 64'd0);
    chk("rst_bcd_out", 64'(bcd_out), 64'd0);
    chk("rst_pulses", 64'({upd_strobe, timeout_err, upd_slot}), 64'd0);
    reset_n = 1'b1;

    // Full-scale sample on a single-slot scan
    ch_mask = 4'b0001; enable = 1'b1;
    sample(0, 4095); collect();
    check_bcd(0);

    // Mid-scale and the low boundary codes
    sample(0, 2048); collect();
    check_bcd(0);
    sample(0, 0);    collect();
    sample(0, 1);    collect();

    // Two-slot mask: channels alternate 1,3,1,3
    ch_mask = 4'b0101;
    sample(0, 1000); collect();
    sample(2, 3000); collect();
    sample(0, 4000); collect();
    sample(2, 100);  collect();
    chk("mv_slot1_zero", 64'(mv_out[1*MV_W +: MV_W]), 64'd0);
    chk("mv_slot3_zero", 64'(mv_out[3*MV_W +: MV_W]), 64'd0);
    check_bcd(2);
    check_bcd(5);

    // Mismatched response, then timeout
    ch_mask = 4'b0001;
    wait_cmd(1);
    respond(2, 4095);
    to_cnt = 0; st_cnt = 0;
    for (int n = 0; n < TIMEOUT_CYC + 50 && cmd_valid !== 1'b1; n++) begin
      @(negedge Clk);
      if (timeout_err === 1'b1) to_cnt++;
      if (upd_strobe === 1'b1) st_cnt++;
    end
    chk("timeout_pulses", 64'(to_cnt), 64'd1);
    chk("timeout_no_strobe", 64'(st_cnt), 64'd0);
    chk("timeout_mv_kept", 64'(mv_out[0 +: MV_W]), 64'(exp_mv[0]));
    chk("timeout_reissue_valid", 64'(cmd_valid), 64'd1);
    chk("timeout_reissue_ch", 64'(cmd_channel), 64'd1);

    // Enable dropped while scaling: the slot still completes
    disp_sel = 3'd0;
    strobes0 = strobes; pushes0 = pushes;
    wait_cmd(1);
    respond(1, 2048);
    enable = 1'b0;
    model_sample(0, 2048);
    collect();
    chk("disable_strobe_count", 64'(strobes - strobes0), 64'(pushes - pushes0));
    n_cmd = 0;
    repeat (30) begin @(negedge Clk); if (cmd_valid === 1'b1) n_cmd++; end
    chk("no_cmd_after_disable", 64'(n_cmd), 64'd0);

    // Asynchronous reset while waiting for a response
    enable = 1'b1;
    wait_cmd(1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_cmd", 64'({cmd_valid, cmd_channel}), 64'd0);
    chk("arst_mv_out", 64'(mv_out), 64'd0);
    chk("arst_bcd_out", 64'(bcd_out), 64'd0);
    chk("arst_pulses", 64'({upd_strobe, timeout_err, upd_slot}), 64'd0);
    enable = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin exp_mv[i] = 0; acc_m[i] = 0; cnt_m[i] = 0; end
    sb.delete();
    @(negedge Clk);
    reset_n = 1'b1;
    repeat (5) @(negedge Clk);
    chk("post_reset_no_cmd", 64'(cmd_valid), 64'd0);

    // Four-sample block: averaged or written through
    ch_mask = 4'b0001; enable = 1'b1;
    strobes0 = strobes; pushes0 = pushes;
    for (int k = 0; k < 4; k++) begin
      sample(0, t6[k]); collect();
    end
    chk("block_strobes_model", 64'(strobes - strobes0), 64'(pushes - pushes0));
`ifdef ADC_SCAN_AVG_EN
    chk("block_strobes", 64'(strobes - strobes0), 64'd1);
    chk("block_final_mv", 64'(mv_out[0 +: MV_W]), 64'd2500);
`else
    chk("block_strobes", 64'(strobes - strobes0), 64'd4);
    chk("block_final_mv", 64'(mv_out[0 +: MV_W]), 64'd5000);
`endif
    enable = 1'b0;
    repeat (5) @(negedge Clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
